transfer_unit: RTL and testbench

- Register-transfer datapath directly downstream of the control sequencer.
- Holds PC, SP, MA, MD, IR, A, AP and OUT, and executes the 4-bit transfer command, PC-increment and SP inc/dec strobes each cycle.
- Owns the memory port and stalls the sequencer while a read is outstanding.
- Drives IR back to the sequencer as its opcode.

---
 rtl/edulent_pkg.sv | 49 ++++
 rtl/transfer_unit_if.sv | 30 +++
 rtl/transfer_unit_stack_pointer.sv | 71 +++++++
 rtl/transfer_unit.sv | 162 ++++++++++++++++
 tb/tb_transfer_unit.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/edulent_pkg.sv
// -----------------------------------------------------------------------------
// edulent_pkg
// Shared types and defaults for the control sequencer and the transfer unit.
//   transfer_cmd_t : 4-bit register-transfer command (0..F)
//   sp_op_t        : stack pointer operation decoded from the 2-bit SP strobe
//   DW_DEFAULT, PC_RESET_DEFAULT, SP_RESET_DEFAULT : parameter defaults
//   decode_sp_op() : maps the raw 2-bit SP strobe onto sp_op_t
// -----------------------------------------------------------------------------
package edulent_pkg;

    localparam int              DW_DEFAULT       = 8;
    localparam logic [7:0]      PC_RESET_DEFAULT = 8'h00;
    localparam logic [7:0]      SP_RESET_DEFAULT = 8'hFF;

    typedef enum logic [3:0] {
        CMD_NOP      = 4'h0,  // no transfer
        CMD_MA_PC    = 4'h1,  // MA   <- PC
        CMD_MD_MEM   = 4'h2,  // MD   <- M[MA] (multi-cycle read)
        CMD_IR_MD    = 4'h3,  // IR   <- MD
        CMD_MA_MD    = 4'h4,  // MA   <- MD
        CMD_A_MD     = 4'h5,  // A/AP <- MD
        CMD_MA_AP    = 4'h6,  // MA   <- AP
        CMD_MA_SP    = 4'h7,  // MA   <- SP
        CMD_MD_A     = 4'h8,  // MD   <- A/AP
        CMD_MEM_MD   = 4'h9,  // M[MA] <- MD
        CMD_A_ALU    = 4'hA,  // A/AP <- R
        CMD_PC_MD    = 4'hB,  // PC   <- MD
        CMD_A_IN     = 4'hC,  // A    <- IN
        CMD_OUT_A    = 4'hD,  // OUT  <- A
        CMD_PC_AP    = 4'hE,  // PC   <- AP
        CMD_MD_PC    = 4'hF   // MD   <- PC
    } transfer_cmd_t;

    typedef enum logic [1:0] {
        SP_HOLD = 2'b00,
        SP_INC  = 2'b01,
        SP_DEC  = 2'b10
    } sp_op_t;

    // 01 increments, 10 decrements, 00 and 11 both hold.
    function automatic sp_op_t decode_sp_op(input logic [1:0] bits);
        case (bits)
            2'b01:   return SP_INC;
            2'b10:   return SP_DEC;
            default: return SP_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/transfer_unit_if.sv
// -----------------------------------------------------------------------------
// transfer_unit_if
// Memory port of the transfer unit.
//   mem_addr   : address (always MA)          master -> slave
//   mem_wdata  : write data (always MD)       master -> slave
//   mem_re     : one-cycle read request       master -> slave
//   mem_we     : one-cycle write strobe       master -> slave
//   mem_rdata  : read data                    slave  -> master
//   mem_rvalid : read data valid              slave  -> master
// -----------------------------------------------------------------------------
interface transfer_unit_if #(
    parameter int DW = edulent_pkg::DW_DEFAULT
);
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_re;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          mem_rvalid;

    modport master (
        output mem_addr, mem_wdata, mem_re, mem_we,
        input  mem_rdata, mem_rvalid
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_re, mem_we,
        output mem_rdata, mem_rvalid
    );
endinterface

// File: rtl/transfer_unit_stack_pointer.sv
// -----------------------------------------------------------------------------
// stack_pointer
// Stack pointer register with increment/decrement. The stack grows down.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_en         : apply i_op on this edge (command completes this cycle)
//   i_op         : SP_HOLD / SP_INC / SP_DEC
//   o_sp         : current stack pointer
//   o_fault      : sticky wrap fault (only with TRANSFER_SP_GUARD_EN)
// Macro TRANSFER_SP_GUARD_EN: when defined, a wrapping update is suppressed
// and flagged on o_fault; when undefined, SP wraps modulo 2^DW.
// -----------------------------------------------------------------------------
module stack_pointer
    import edulent_pkg::*;
#(
    parameter int            DW       = DW_DEFAULT,
    parameter logic [DW-1:0] SP_RESET = SP_RESET_DEFAULT
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  sp_op_t        i_op,
`ifdef TRANSFER_SP_GUARD_EN
    output logic          o_fault,
`endif
    output logic [DW-1:0] o_sp
);

    localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

    logic [DW-1:0] sp;

`ifdef TRANSFER_SP_GUARD_EN
    logic fault;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sp    <= SP_RESET;
            fault <= 1'b0;
        end else if (i_en) begin
            case (i_op)
                SP_INC: begin
                    if (sp == '1) fault <= 1'b1;
                    else          sp    <= sp + ONE;
                end
                SP_DEC: begin
                    if (sp == '0) fault <= 1'b1;
                    else          sp    <= sp - ONE;
                end
                default: ;
            endcase
        end
    end

    assign o_fault = fault;
`else
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sp <= SP_RESET;
        end else if (i_en) begin
            case (i_op)
                SP_INC:  sp <= sp + ONE;
                SP_DEC:  sp <= sp - ONE;
                default: ;
            endcase
        end
    end
`endif

    assign o_sp = sp;

endmodule

// File: rtl/transfer_unit.sv
// -----------------------------------------------------------------------------
// transfer_unit
// Register-transfer datapath behind the control sequencer. Holds PC, SP, MA,
// MD, IR, A, AP and OUT and executes one transfer command per completed cycle.
// A memory read (command 2) stalls the sequencer until read data returns.
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_transfer_cmd    : 4-bit transfer command (transfer_cmd_t)
//   i_inc_pc          : PC+1 when the command completes (dropped on PC loads)
//   i_inc_dec_sp      : 01 = SP+1, 10 = SP-1, else hold
//   i_dst_ap          : commands 5, 8, A use AP instead of A
//   i_alu_result      : ALU result R
//   i_in_data         : input port value
//   mem               : memory port (transfer_unit_if.master)
//   o_stall           : sequencer must hold its outputs while high
//   o_ir              : instruction register (opcode to the sequencer)
//   o_a, o_ap, o_pc, o_sp : architectural registers
//   o_out_data        : OUT register
//   o_out_valid       : one-cycle pulse alongside a freshly loaded OUT
//   o_sp_fault        : sticky SP wrap fault (only with TRANSFER_SP_GUARD_EN)
// Macro TRANSFER_SP_GUARD_EN enables the SP wrap guard and o_sp_fault.
// o_ir is 8 bits and takes MD[7:0], so DW must be at least 8.
// -----------------------------------------------------------------------------
module transfer_unit
    import edulent_pkg::*;
#(
    parameter int            DW       = DW_DEFAULT,
    parameter logic [DW-1:0] SP_RESET = SP_RESET_DEFAULT,
    parameter logic [DW-1:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [3:0]    i_transfer_cmd,
    input  logic          i_inc_pc,
    input  logic [1:0]    i_inc_dec_sp,
    input  logic          i_dst_ap,
    input  logic [DW-1:0] i_alu_result,
    input  logic [DW-1:0] i_in_data,
    transfer_unit_if.master mem,
    output logic          o_stall,
    output logic [7:0]    o_ir,
    output logic [DW-1:0] o_a,
    output logic [DW-1:0] o_ap,
    output logic [DW-1:0] o_pc,
    output logic [DW-1:0] o_sp,
    output logic [DW-1:0] o_out_data,
`ifdef TRANSFER_SP_GUARD_EN
    output logic          o_sp_fault,
`endif
    output logic          o_out_valid
);

    localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t        state;
    transfer_cmd_t cmd;
    logic [DW-1:0] pc, ma, md, a, ap, out_data;
    logic [7:0]    ir;
    logic          out_valid;
    logic          stall;
    logic          done;
    logic          pc_load;

    assign cmd = transfer_cmd_t'(i_transfer_cmd);

    // A read stalls in its issue cycle and then until rvalid arrives; every
    // other command completes in the cycle it is presented.
    // NOTE: always_comb assigns every output on every path first, so no latch is inferred.
    always_comb begin
        stall = 1'b0;
        if (state == IDLE) stall = (cmd == CMD_MD_MEM);
        else               stall = !mem.mem_rvalid;
    end

    assign done    = !stall;
    assign pc_load = (cmd == CMD_PC_MD) || (cmd == CMD_PC_AP);

    // NOTE: sequential state uses non-blocking assignments so every source is read pre-edge (e.g. MA<-SP sees old SP during SP-1).
    // NOTE: every register here has a reset value; there are no memory arrays to leave unreset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            pc        <= PC_RESET;
            ma        <= '0;
            md        <= '0;
            ir        <= '0;
            a         <= '0;
            ap        <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd == CMD_MD_MEM) state <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (mem.mem_rvalid) begin
                        md    <= mem.mem_rdata;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (done) begin
                case (cmd)
                    CMD_MA_PC: ma <= pc;
                    CMD_IR_MD: ir <= md[7:0];
                    CMD_MA_MD: ma <= md;
                    CMD_A_MD:  if (i_dst_ap) ap <= md; else a <= md;
                    CMD_MA_AP: ma <= ap;
                    CMD_MA_SP: ma <= o_sp;
                    CMD_MD_A:  md <= i_dst_ap ? ap : a;
                    CMD_A_ALU: if (i_dst_ap) ap <= i_alu_result; else a <= i_alu_result;
                    CMD_PC_MD: pc <= md;
                    CMD_A_IN:  a  <= i_in_data;
                    CMD_OUT_A: begin
                        out_data  <= a;
                        out_valid <= 1'b1;
                    end
                    CMD_PC_AP: pc <= ap;
                    CMD_MD_PC: md <= pc;
                    default: ;  // NOP, read data and memory write handled elsewhere
                endcase

                // PC loads win over the increment strobe.
                if (i_inc_pc && !pc_load) pc <= pc + ONE;
            end
        end
    end

    stack_pointer #(
        .DW       (DW),
        .SP_RESET (SP_RESET)
    ) u_stack_pointer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (done),
        .i_op    (decode_sp_op(i_inc_dec_sp)),
`ifdef TRANSFER_SP_GUARD_EN
        .o_fault (o_sp_fault),
`endif
        .o_sp    (o_sp)
    );

    assign mem.mem_addr  = ma;
    assign mem.mem_wdata = md;
    assign mem.mem_re    = (state == IDLE) && (cmd == CMD_MD_MEM);
    assign mem.mem_we    = (cmd == CMD_MEM_MD);

    assign o_stall     = stall;
    assign o_ir        = ir;
    assign o_a         = a;
    assign o_ap        = ap;
    assign o_pc        = pc;
    assign o_out_data  = out_data;
    assign o_out_valid = out_valid;

endmodule

// File: tb/tb_transfer_unit.sv
// -----------------------------------------------------------------------------
// tb_transfer_unit
// Directed bench for transfer_unit. Memory reads/writes and OUT pulses are
// predicted into queues by the stimulus and popped by a monitor on the falling
// edge; register state is compared directly after each rising edge.
// Build with TRANSFER_SP_GUARD_EN to exercise the SP wrap guard.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_transfer_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] cmd = 4'h0;
    logic       inc_pc = 1'b0;
    logic [1:0] inc_dec_sp = 2'b00;
    logic       dst_ap = 1'b0;
    logic [7:0] alu_result = 8'h00;
    logic [7:0] in_data = 8'h00;
    logic       stall, out_valid;
    logic [7:0] ir, a, ap, pc, sp, out_data;
`ifdef TRANSFER_SP_GUARD_EN
    logic       sp_fault;
`endif

    transfer_unit_if #(.DW(8)) mem_if ();

    transfer_unit dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_transfer_cmd (cmd),
        .i_inc_pc       (inc_pc),
        .i_inc_dec_sp   (inc_dec_sp),
        .i_dst_ap       (dst_ap),
        .i_alu_result   (alu_result),
        .i_in_data      (in_data),
        .mem            (mem_if),
        .o_stall        (stall),
        .o_ir           (ir),
        .o_a            (a),
        .o_ap           (ap),
        .o_pc           (pc),
        .o_sp           (sp),
        .o_out_data     (out_data),
`ifdef TRANSFER_SP_GUARD_EN
        .o_sp_fault     (sp_fault),
`endif
        .o_out_valid    (out_valid)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  re_q[$];   // expected read addresses
    logic [15:0] wr_q[$];   // expected {addr, data} writes
    logic [7:0]  out_q[$];  // expected OUT values

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every strobe the DUT raises must match a prediction.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_if.mem_re) begin
                if (re_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_read: addr %0h, expected no read", mem_if.mem_addr);
                end else check("read_addr", mem_if.mem_addr, re_q.pop_front());
            end
            if (mem_if.mem_we) begin
                if (wr_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_write: %0h, expected no write", {mem_if.mem_addr, mem_if.mem_wdata});
                end else check("write_addr_data", {mem_if.mem_addr, mem_if.mem_wdata}, wr_q.pop_front());
            end
            if (out_valid) begin
                if (out_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_out_valid: data %0h, expected no pulse", out_data);
                end else check("out_data", out_data, out_q.pop_front());
            end
        end
    end

    // One completed single-cycle command; returns #1 after the closing edge.
    task automatic step(input logic [3:0] c, input logic inc = 1'b0,
                        input logic [1:0] spop = 2'b00, input logic dst = 1'b0);
        cmd = c; inc_pc = inc; inc_dec_sp = spop; dst_ap = dst;
        @(posedge clk); #1;
        cmd = 4'h0; inc_pc = 1'b0; inc_dec_sp = 2'b00; dst_ap = 1'b0;
    endtask

    // Command 2 with rvalid raised after nwait stalled cycles; counts stalls.
    task automatic do_read(input int nwait, input logic [7:0] data, input logic inc,
                           input logic [1:0] spop, output int stalls);
        cmd = 4'h2; inc_pc = inc; inc_dec_sp = spop; stalls = 0;
        for (int i = 0; i < nwait; i++) begin
            @(negedge clk); if (stall) stalls++;
            @(posedge clk); #1;
        end
        mem_if.mem_rdata = data; mem_if.mem_rvalid = 1'b1;
        @(negedge clk); if (stall) stalls++;
        @(posedge clk); #1;
        mem_if.mem_rvalid = 1'b0;
        cmd = 4'h0; inc_pc = 1'b0; inc_dec_sp = 2'b00;
    endtask

    initial begin
        int stalls;
        mem_if.mem_rdata  = 8'h00;
        mem_if.mem_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("reset_pc", pc, 8'h00);
        check("reset_sp", sp, 8'hFF);
        check("reset_a_ap_ir", {a, ap, ir}, 24'h0);
        check("reset_md_ma", {mem_if.mem_wdata, mem_if.mem_addr}, 16'h0);
        check("reset_strobes", {stall, mem_if.mem_re, mem_if.mem_we, out_valid}, 4'b0);
        step(4'h0);
        check("idle_pc", pc, 8'h00);

        // Fetch: MA<-PC, read with 3 stall cycles, IR<-MD
        step(4'h1);
        check("fetch_ma", mem_if.mem_addr, 8'h00);
        re_q.push_back(8'h00);
        do_read(3, 8'h19, 1'b1, 2'b00, stalls);
        check("fetch_stall_cycles", stalls, 3);
        check("fetch_md", mem_if.mem_wdata, 8'h19);
        check("fetch_pc_once", pc, 8'h01);
        step(4'h3);
        check("fetch_ir", ir, 8'h19);

        // Push: A=5A, SP-1, MA<-SP, MD<-A, M[MA]<-MD
        in_data = 8'h5A;
        step(4'hC);
        check("push_a", a, 8'h5A);
        step(4'h0, 1'b0, 2'b10);
        check("push_sp", sp, 8'hFE);
        step(4'h7);
        check("push_ma", mem_if.mem_addr, 8'hFE);
        step(4'h8);
        wr_q.push_back({8'hFE, 8'h5A});
        step(4'h9);

        // Pop: MA<-SP, read with SP+1 at minimum latency, AP<-MD
        step(4'h7);
        re_q.push_back(8'hFE);
        do_read(1, 8'h5A, 1'b0, 2'b01, stalls);
        check("pop_stall_cycles", stalls, 1);
        check("pop_sp", sp, 8'hFF);
        step(4'h5, 1'b0, 2'b00, 1'b1);
        check("pop_ap", ap, 8'h5A);
        check("pop_a_untouched", a, 8'h5A);

        // Jumps: PC<-MD and PC<-AP drop the increment
        in_data = 8'h40;
        step(4'hC);
        step(4'h8);
        step(4'hB, 1'b1);
        check("jump_pc_md", pc, 8'h40);
        alu_result = 8'h80;
        step(4'hA, 1'b0, 2'b00, 1'b1);
        check("alu_to_ap", ap, 8'h80);
        check("alu_a_untouched", a, 8'h40);
        step(4'hE, 1'b1);
        check("jump_pc_ap", pc, 8'h80);

        // Old-value sampling
        step(4'hF, 1'b1);
        check("md_old_pc", mem_if.mem_wdata, 8'h80);
        check("pc_after_inc", pc, 8'h81);
        step(4'h7, 1'b0, 2'b10);
        check("ma_old_sp", mem_if.mem_addr, 8'hFF);
        check("sp_dec", sp, 8'hFE);
        step(4'h0, 1'b0, 2'b01);
        check("sp_back", sp, 8'hFF);

        // OUT: single valid pulse with new data
        in_data = 8'h33;
        step(4'hC, 1'b0, 2'b00, 1'b1);
        check("cmd_c_writes_a", {a, ap}, 16'h3380);
        out_q.push_back(8'h33);
        step(4'hD);
        check("out_now", {out_valid, out_data}, 9'h133);
        step(4'h0);
        check("out_pulse_gone", out_valid, 1'b0);

        // SP wrap / guard
        step(4'h0, 1'b0, 2'b01);
`ifdef TRANSFER_SP_GUARD_EN
        check("guard_sp_held", sp, 8'hFF);
        check("guard_fault_set", sp_fault, 1'b1);
        step(4'h0);
        check("guard_fault_sticky", sp_fault, 1'b1);
`else
        check("wrap_up", sp, 8'h00);
        step(4'h0, 1'b0, 2'b10);
        check("wrap_down", sp, 8'hFF);
`endif

        // Reset in the middle of a read; a late rvalid is discarded
        re_q.push_back(8'hFF);
        cmd = 4'h2;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; cmd = 4'h0;
        mem_if.mem_rdata = 8'hAA; mem_if.mem_rvalid = 1'b1;
        @(posedge clk); #1;
        mem_if.mem_rvalid = 1'b0;
        check("rst_md_stays_0", mem_if.mem_wdata, 8'h00);
        check("rst_pc_sp", {pc, sp}, 16'h00FF);
`ifdef TRANSFER_SP_GUARD_EN
        check("rst_fault_cleared", sp_fault, 1'b0);
`endif
        // A fresh read must be issued from IDLE
        re_q.push_back(8'h00);
        cmd = 4'h2; #1;
        check("rst_idle_issue", {stall, mem_if.mem_re}, 2'b11);
        @(posedge clk); #1;
        mem_if.mem_rdata = 8'h77; mem_if.mem_rvalid = 1'b1; #1;
        check("rst_wait_release", {stall, mem_if.mem_re}, 2'b00);
        @(posedge clk); #1;
        mem_if.mem_rvalid = 1'b0; cmd = 4'h0;
        check("rst_read_md", mem_if.mem_wdata, 8'h77);

        step(4'h0);
        step(4'h0);
        check("reads_left", re_q.size(), 0);
        check("writes_left", wr_q.size(), 0);
        check("outs_left", out_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
